reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 16 +
 rtl/reset_sequencer_if.sv | 25 ++
 rtl/sat_counter.sv | 21 ++
 rtl/reset_sequencer.sv | 106 ++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and limits for the reset sequencer
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int MAX_DOMAINS = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/status bundle between a reset source and the sequencer
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);

  logic                   sw_rst_req;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   all_released;
  logic                   timeout;

  modport master (
    output sw_rst_req,
    input  dom_rst,
    input  all_released,
    input  timeout
  );

  modport slave (
    input  sw_rst_req,
    output dom_rst,
    output all_released,
    output timeout
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that clears synchronously and sticks at MAX
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (inc && count != WIDTH'(MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged multi-domain reset release; RESET_SEQUENCER_TIMEOUT_EN adds the run timeout
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 25,
  parameter int STAGE_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);

  localparam int SEQ_MAX = max_int(HOLD_CYCLES, STAGE_GAP);
  localparam int SEQ_W   = $clog2(SEQ_MAX) + 1;
  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(STAGE_GAP - 1);

  state_t                 state;
  logic [NUM_DOMAINS-1:0] dom_rst_q;
  logic [NUM_DOMAINS-1:0] dom_next;
  logic                   all_released_q;
  logic [SEQ_W-1:0]       seq_cnt;
  logic                   sw;
  logic                   hold_done;
  logic                   gap_done;
  logic                   seq_clr;

  assign sw        = bus.sw_rst_req;
  assign hold_done = (state == HOLD) && !sw && (seq_cnt == HOLD_LAST);
  assign gap_done  = (state == RELEASE) && !sw && (seq_cnt == GAP_LAST);
  assign seq_clr   = sw || hold_done || gap_done || (state == RUN);
  // Domains release low-index first, so each stage shifts one more zero in from bit 0.
  assign dom_next  = dom_rst_q << 1;

  sat_counter #(
    .WIDTH (SEQ_W),
    .MAX   (SEQ_MAX)
  ) u_seq_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (seq_clr),
    .inc   (1'b1),
    .count (seq_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst || sw) begin
      state          <= HOLD;
      dom_rst_q      <= '1;
      all_released_q <= 1'b0;
    end else begin
      case (state)
        HOLD, RELEASE: begin
          if (hold_done || gap_done) begin
            dom_rst_q <= dom_next;
            if (dom_next == '0) begin
              state          <= RUN;
              all_released_q <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RUN:     state <= RUN;
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.dom_rst      = dom_rst_q;
  assign bus.all_released = all_released_q;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [RUN_W-1:0] run_cnt;
  logic             timeout_q;

  sat_counter #(
    .WIDTH (RUN_W),
    .MAX   (TIMEOUT_CYCLES)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (sw || (state != RUN)),
    .inc   (1'b1),
    .count (run_cnt)
  );

  // Sticky across software re-sequencing; only the hard reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if ((state == RUN) && !sw && (run_cnt == RUN_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule
